mcu_dmem_responder: RTL
=======================

// Module: mcu_dmem_responder
// PURPOSE
//  Data-memory responder for control-processor LSU requests (load, store, AMO/LR/SC) produced by decode/EX.
//  Owns the single-port word SRAM interface. Runs AMO read-modify-write sequences and the LR/SC reservation.
//  Returns the old word (or SC status) on a valid/ready response channel. Sits between MCU MEM stage and local DMEM.
// PARAMETERS
//  AW     32  byte-address width of req_addr
//  DEPTH  4096  SRAM depth in 32-bit words; word index width = $clog2(DEPTH)
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   async active-low reset
//  req_valid    in   1   request valid
//  req_ready    out  1   high only in IDLE
//  req_addr     in   AW  byte address
//  req_wdata    in   32  store data / AMO operand (rs2)
//  req_wstrb    in   4   store byte enables
//  req_read     in   1   load
//  req_write    in   1   store
//  req_amo      in   1   atomic; overrides read/write
//  req_funct5   in   5   AMO op (insn[31:27])
//  rsp_valid    out  1   response valid, held until rsp_ready
//  rsp_ready    in   1   response accept
//  rsp_rdata    out  32  load word / AMO old value / SC status (0=ok, 1=fail)
//  rsp_err      out  1   misaligned, out-of-range or illegal request
//  sram_en      out  1   SRAM access strobe
//  sram_we      out  4   byte write enables (0 = read)
//  sram_addr    out  $clog2(DEPTH)  word index
//  sram_wdata   out  32  write data
//  sram_rdata   in   32  read data, valid 1 cycle after read strobe
// BEHAVIOUR
//  - Reset: state=IDLE, resv_valid=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, sram_en=0, sram_we=0.
//  - Accept on req_valid & req_ready (t0). Latch all req fields. rsp_ready is ignored outside RESP.
//  - FSM: IDLE, ISSUE, RDATA, WRBACK, RESP.
//    - Load/LR: ISSUE t1 read -> RDATA t2 capture -> RESP t3. LR sets resv_valid=1 and resv_addr=word.
//    - Store: ISSUE t1 write with req_wstrb -> RESP t2. rsp_rdata=0.
//    - AMO: ISSUE t1 read -> RDATA t2 capture old, compute new -> WRBACK t3 write 4'hF -> RESP t4. rsp_rdata=old.
//    - SC: in ISSUE, if resv_valid & resv_addr==word then write 4'hF, rsp_rdata=0; else no write, rsp_rdata=1.
//      Go to RESP t2. Any SC clears resv_valid.
//    - Error (go IDLE->RESP at t1, no SRAM access, rsp_err=1, rsp_rdata=0):
//      AMO with addr[1:0]!=0; word index >= DEPTH; neither read/write/amo set; read&write without amo;
//      unsupported funct5 with amo; store with wstrb=0.
//  - Reservation: any SRAM write (store, AMO, successful SC) to resv_addr clears resv_valid.
//    Write and clear happen in the same cycle as the write.
//  - RESP: hold rsp_valid/rdata/err stable until rsp_ready. Next cycle go IDLE; req_ready rises then (no same-cycle reaccept).
//  - funct5: ADD 00000, SWAP 00001, LR 00010, SC 00011, XOR 00100, OR 01000, AND 01100,
//    MIN 10000, MAX 10100, MINU 11000, MAXU 11100.
//    MIN/MAX signed 32-bit compare; MINU/MAXU unsigned; ADD wraps mod 2^32.
//  - Loads return the full aligned word; byte/half extraction and sign-extension stay in the core.
//  - sram_en/we are driven combinationally from state only (one cycle wide). Never asserted in IDLE/RESP.
//  - Async reset mid-sequence aborts: no partial write is issued after reset, and the reservation is lost.
// STRUCTURE
//  - mcu_isa_pkg gains: AMO_* funct5 localparams and the dmem_state_t enum.
//  - Sub-module mcu_amo_alu: combinational (funct5, old, operand) -> new word; instantiated once.
// TESTING
//  1 Store 0xDEADBEEF wstrb F @0x10, load @0x10 -> store rsp t2 rdata 0; load rsp t3 rdata 0xDEADBEEF.
//  2 mem[0x20]=5; AMOADD 3 -> rsp 5, mem 8. AMOMIN -1 -> rsp 8, mem 0xFFFFFFFF.
//    AMOMAXU 1 -> rsp 0xFFFFFFFF, mem unchanged.
//  3 LR @0x40, SC @0x40 data 7 -> SC rdata 0, mem 7. Second SC @0x40 -> rdata 1, no sram write.
//  4 LR @0x40, store @0x40, SC @0x40 -> SC fails (1). LR @0x40, SC @0x44 -> fails, reservation cleared.
//  5 AMO @0x22, load addr DEPTH*4 -> rsp t1, rsp_err=1, sram_en never high.
//  6 rsp_ready low 5 cycles in RESP -> rsp fields stable, req_ready=0. Reset asserted in WRBACK
//    -> all outputs reset immediately, no sram write.

Source files
------------

// File: rtl/mcu_isa_pkg.sv
// Shared MCU ISA constants: AMO funct5 encodings and the DMEM responder state encoding.
package mcu_isa_pkg;

    localparam logic [4:0] AMO_ADD  = 5'b00000;
    localparam logic [4:0] AMO_SWAP = 5'b00001;
    localparam logic [4:0] AMO_LR   = 5'b00010;
    localparam logic [4:0] AMO_SC   = 5'b00011;
    localparam logic [4:0] AMO_XOR  = 5'b00100;
    localparam logic [4:0] AMO_OR   = 5'b01000;
    localparam logic [4:0] AMO_AND  = 5'b01100;
    localparam logic [4:0] AMO_MIN  = 5'b10000;
    localparam logic [4:0] AMO_MAX  = 5'b10100;
    localparam logic [4:0] AMO_MINU = 5'b11000;
    localparam logic [4:0] AMO_MAXU = 5'b11100;

    typedef logic [2:0] dmem_state_t;

    localparam dmem_state_t DMEM_IDLE   = 3'd0;
    localparam dmem_state_t DMEM_ISSUE  = 3'd1;
    localparam dmem_state_t DMEM_RDATA  = 3'd2;
    localparam dmem_state_t DMEM_WRBACK = 3'd3;
    localparam dmem_state_t DMEM_RESP   = 3'd4;

    function automatic logic amo_funct5_legal(input logic [4:0] funct5);
        logic legal;
        case (funct5)
            AMO_ADD, AMO_SWAP, AMO_LR, AMO_SC, AMO_XOR, AMO_OR, AMO_AND,
            AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: legal = 1'b1;
            default:                              legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mcu_amo_alu.sv
// Combinational AMO datapath: computes the word written back for a read-modify-write AMO.
module mcu_amo_alu
    import mcu_isa_pkg::*;
(
    input  logic [4:0]  funct5,
    input  logic [31:0] old_word,
    input  logic [31:0] operand,
    output logic [31:0] new_word
);

    always_comb begin
        new_word = old_word;
        case (funct5)
            AMO_ADD:  new_word = old_word + operand;
            AMO_SWAP: new_word = operand;
            AMO_XOR:  new_word = old_word ^ operand;
            AMO_OR:   new_word = old_word | operand;
            AMO_AND:  new_word = old_word & operand;
            AMO_MIN:  new_word = ($signed(old_word) < $signed(operand)) ? old_word : operand;
            AMO_MAX:  new_word = ($signed(old_word) > $signed(operand)) ? old_word : operand;
            AMO_MINU: new_word = (old_word < operand) ? old_word : operand;
            AMO_MAXU: new_word = (old_word > operand) ? old_word : operand;
            default:  new_word = old_word;
        endcase
    end

endmodule

// File: rtl/mcu_dmem_responder.sv
// Data-memory responder: serves loads, stores, AMOs and LR/SC against a single-port word SRAM,
// returning the old word (or SC status) on a valid/ready response channel.
module mcu_dmem_responder
    import mcu_isa_pkg::*;
#(
    parameter int unsigned AW    = 32,
    parameter int unsigned DEPTH = 4096,
    localparam int unsigned IW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    input  logic [3:0]    req_wstrb,
    input  logic          req_read,
    input  logic          req_write,
    input  logic          req_amo,
    input  logic [4:0]    req_funct5,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          sram_en,
    output logic [3:0]    sram_we,
    output logic [IW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);

    dmem_state_t   state_q, state_d;
    logic [IW-1:0] word_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic [4:0]    funct5_q;
    logic          is_store_q, is_rmw_q, is_lr_q, is_sc_q;
    logic [31:0]   new_q;
    logic          resv_valid_q;
    logic [IW-1:0] resv_addr_q;
    logic [31:0]   rsp_rdata_q;
    logic          rsp_err_q;

    logic          range_err, dec_err, sc_hit;
    logic [31:0]   alu_new;

    assign range_err = (64'(req_addr[AW-1:2]) >= 64'(DEPTH));

    always_comb begin
        dec_err = range_err;
        if (req_amo) begin
            dec_err = dec_err || (req_addr[1:0] != 2'b00) || !amo_funct5_legal(req_funct5);
        end else begin
            dec_err = dec_err || (!req_read && !req_write) || (req_read && req_write)
                      || (req_write && (req_wstrb == 4'h0));
        end
    end

    assign sc_hit = resv_valid_q && (resv_addr_q == word_q);

    mcu_amo_alu u_amo_alu (
        .funct5   (funct5_q),
        .old_word (sram_rdata),
        .operand  (wdata_q),
        .new_word (alu_new)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            DMEM_IDLE:   if (req_valid) state_d = dec_err ? DMEM_RESP : DMEM_ISSUE;
            DMEM_ISSUE:  state_d = (is_store_q || is_sc_q) ? DMEM_RESP : DMEM_RDATA;
            DMEM_RDATA:  state_d = is_rmw_q ? DMEM_WRBACK : DMEM_RESP;
            DMEM_WRBACK: state_d = DMEM_RESP;
            DMEM_RESP:   if (rsp_ready) state_d = DMEM_IDLE;
            default:     state_d = DMEM_IDLE;
        endcase
    end

    // A failed SC issues no SRAM access at all.
    always_comb begin
        sram_en = 1'b0;
        sram_we = 4'h0;
        case (state_q)
            DMEM_ISSUE: begin
                if (is_sc_q) begin
                    sram_en = sc_hit;
                    sram_we = sc_hit ? 4'hF : 4'h0;
                end else begin
                    sram_en = 1'b1;
                    sram_we = is_store_q ? wstrb_q : 4'h0;
                end
            end
            DMEM_WRBACK: begin
                sram_en = 1'b1;
                sram_we = 4'hF;
            end
            default: ;
        endcase
    end

    assign sram_addr  = word_q;
    assign sram_wdata = (state_q == DMEM_WRBACK) ? new_q : wdata_q;
    assign req_ready  = (state_q == DMEM_IDLE);
    assign rsp_valid  = (state_q == DMEM_RESP);
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= DMEM_IDLE;
            word_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            funct5_q     <= '0;
            is_store_q   <= 1'b0;
            is_rmw_q     <= 1'b0;
            is_lr_q      <= 1'b0;
            is_sc_q      <= 1'b0;
            new_q        <= '0;
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                DMEM_IDLE: begin
                    if (req_valid) begin
                        word_q      <= req_addr[IW+1:2];
                        wdata_q     <= req_wdata;
                        wstrb_q     <= req_wstrb;
                        funct5_q    <= req_funct5;
                        is_store_q  <= !req_amo && req_write;
                        is_lr_q     <= req_amo && (req_funct5 == AMO_LR);
                        is_sc_q     <= req_amo && (req_funct5 == AMO_SC);
                        is_rmw_q    <= req_amo && (req_funct5 != AMO_LR)
                                       && (req_funct5 != AMO_SC);
                        rsp_err_q   <= dec_err;
                        rsp_rdata_q <= '0;
                    end
                end
                DMEM_ISSUE: if (is_sc_q) rsp_rdata_q <= {31'b0, !sc_hit};
                DMEM_RDATA: begin
                    rsp_rdata_q <= sram_rdata;
                    new_q       <= alu_new;
                end
                default: ;
            endcase

            if ((state_q == DMEM_ISSUE) && is_lr_q) begin
                resv_valid_q <= 1'b1;
                resv_addr_q  <= word_q;
            end else if (((state_q == DMEM_ISSUE) && is_sc_q)
                         || ((sram_we != 4'h0) && (sram_addr == resv_addr_q))) begin
                resv_valid_q <= 1'b0;
            end
        end
    end

endmodule
